// File: rtl/t_toggle_pkg.sv
// t_toggle_pkg: shared FSM states and widths for the toggle arbiter
package t_toggle_pkg;
    typedef enum logic [1:0] {IDLE, PULSE, COOL} state_t;
    localparam int COOL_W = 4;
    localparam int TOGGLE_CNT_W = 16;
endpackage

// File: rtl/t_toggle_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first set req at or above ptr with wrap
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PTRW-1:0] win,
    output logic            hit
);
    int k;
    assign hit = |req;
    always_comb begin
        win = '0;
        k = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (req[k]) win = PTRW'(k);
        end
        win_oh = hit ? NREQ'(1) << win : '0;
    end
endmodule

// File: rtl/t_toggle_arbiter.sv
// t_toggle_arbiter: round-robin shared T-cell bank; TTA_TOGGLE_CNT_EN adds a saturating toggle_cnt output
module t_toggle_arbiter
    import t_toggle_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int IDXW     = 3,
    parameter int COOL_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     t_out,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 err_stb
`ifdef TTA_TOGGLE_CNT_EN
    ,
    output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);
    localparam int PTRW = $clog2(NREQ);
    localparam logic [COOL_W-1:0] COOL_LD = COOL_W'(COOL_CYC > 0 ? COOL_CYC - 1 : 0);
    state_t            state, state_n;
    logic [PTRW-1:0]   ptr, ptr_n, win;
    logic [NREQ-1:0]   win_oh, gnt_n;
    logic [COOL_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0]  t_n, q_n;
    logic [IDXW-1:0]   sel_idx;
    logic              busy_n, err_n, hit;

    rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .win_oh (win_oh),
        .win    (win),
        .hit    (hit)
    );

    assign sel_idx = req_idx[win*IDXW +: IDXW];

    // t_out is only nonzero during PULSE, so folding it into q applies the toggle at the end of that cycle
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = '0;
        t_n     = '0;
        err_n   = 1'b0;
        busy_n  = 1'b0;
        q_n     = q ^ t_out;
        case (state)
            IDLE: if (hit) begin
                state_n = PULSE;
                ptr_n   = (win == PTRW'(NREQ - 1)) ? '0 : win + 1'b1;
                gnt_n   = win_oh;
                t_n     = (int'(sel_idx) < WIDTH) ? WIDTH'(1) << sel_idx : '0;
                err_n   = int'(sel_idx) >= WIDTH;
                busy_n  = 1'b1;
            end
            PULSE: begin
                state_n = (COOL_CYC > 0) ? COOL : IDLE;
                cnt_n   = COOL_LD;
                busy_n  = COOL_CYC > 0;
            end
            COOL: begin
                state_n = (cnt == '0) ? IDLE : COOL;
                cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
                busy_n  = cnt != '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            t_out   <= '0;
            q       <= '0;
            busy    <= 1'b0;
            err_stb <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            t_out   <= t_n;
            q       <= q_n;
            busy    <= busy_n;
            err_stb <= err_n;
        end
    end

`ifdef TTA_TOGGLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) toggle_cnt <= '0;
        else if (state == PULSE && |t_out && toggle_cnt != '1) toggle_cnt <= toggle_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_t_toggle_arbiter.sv
// tb_t_toggle_arbiter: random requesters checked every cycle against a timing-level model, plus directed scenarios
module tb_t_toggle_arbiter;
    localparam int NREQ = 4, WIDTH = 6, IDXW = 3, COOL = 2;
    logic clk = 0, rst_n = 0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*IDXW-1:0] req_idx = '0;
    logic [NREQ-1:0] gnt;
    logic [WIDTH-1:0] t_out, q;
    logic busy, err_stb;
    int errs = 0, checks = 0;
    int hold, ptr, mcnt, busy_seen;
    logic [WIDTH-1:0] mq, mt;
    logic [NREQ-1:0] mg;
    logic me, mb, rnd = 0;
`ifdef TTA_TOGGLE_CNT_EN
    logic [15:0] toggle_cnt;
`endif

    t_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW), .COOL_CYC(COOL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_idx(req_idx), .gnt(gnt),
        .t_out(t_out), .q(q), .busy(busy), .err_stb(err_stb)
`ifdef TTA_TOGGLE_CNT_EN
        , .toggle_cnt(toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        hold = 0; ptr = 0; mcnt = 0;
        mq = '0; mt = '0; mg = '0; me = 0; mb = 0;
    endtask

    // Model: a grant occupies 1+COOL cycles during which requests are not looked at
    task automatic mstep();
        int w;
        logic [IDXW-1:0] idx;
        if (mt != '0 && mcnt < 65535) mcnt++;
        mq = mq ^ mt;
        mt = '0; mg = '0; me = 0;
        if (hold > 0) begin
            hold--;
            mb = hold > 0;
        end else if (|req) begin
            w = -1;
            for (int i = 0; i < NREQ; i++)
                if (w < 0 && req[(ptr + i) % NREQ]) w = (ptr + i) % NREQ;
            idx = req_idx[w*IDXW +: IDXW];
            mg[w] = 1'b1;
            if (int'(idx) < WIDTH) mt[idx] = 1'b1;
            else me = 1;
            ptr = (w + 1) % NREQ;
            hold = 1 + COOL;
            mb = 1;
        end else mb = 0;
    endtask

    task automatic cyc();
        mstep();
        @(posedge clk);
        #1;
        chk("gnt", 32'(gnt), 32'(mg));
        chk("t_out", 32'(t_out), 32'(mt));
        chk("q", 32'(q), 32'(mq));
        chk("busy", 32'(busy), 32'(mb));
        chk("err_stb", 32'(err_stb), 32'(me));
`ifdef TTA_TOGGLE_CNT_EN
        chk("toggle_cnt", 32'(toggle_cnt), 32'(mcnt));
`endif
        if (busy) busy_seen++;
        for (int k = 0; k < NREQ; k++) begin
            if (mg[k]) req[k] = 1'b0;
            else if (rnd && !req[k] && $urandom_range(3) == 0) begin
                req[k] = 1'b1;
                req_idx[k*IDXW +: IDXW] = IDXW'($urandom_range(7));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        req = '0;
        mreset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        mreset();
        #12;
        chk("rst_q", 32'(q), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1;

        req = 4'b0001;
        req_idx = {3'd0, 3'd0, 3'd0, 3'd3};
        busy_seen = 0;
        cyc();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_t", 32'(t_out), 32'h08);
        cyc();
        chk("single_q", 32'(q), 32'h08);
        chk("model_single_q", 32'(mq), 32'h08);
        repeat (4) cyc();
        chk("single_busy_len", busy_seen, 1 + COOL);

        do_reset();
        req = 4'b1111;
        req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        repeat (16) cyc();
        chk("contend_q", 32'(q), 32'h0F);
        chk("model_contend_q", 32'(mq), 32'h0F);
        req = 4'b1001;
        cyc();
        chk("ptr_wrap_gnt", 32'(gnt), 32'h1);
        repeat (8) cyc();

        do_reset();
        req = 4'b0110;
        req_idx = {3'd0, 3'd5, 3'd5, 3'd0};
        cyc();
        chk("same_gnt1", 32'(gnt), 32'h2);
        cyc();
        chk("same_q1", 32'(q), 32'h20);
        repeat (3) cyc();
        chk("same_gnt2", 32'(gnt), 32'h4);
        cyc();
        chk("same_q2", 32'(q), 32'h0);

        do_reset();
        req = 4'b0001;
        req_idx = {3'd0, 3'd0, 3'd0, 3'd7};
        cyc();
        chk("inv_gnt", 32'(gnt), 32'h1);
        chk("inv_err", 32'(err_stb), 32'h1);
        chk("inv_t", 32'(t_out), 32'h0);
        cyc();
        chk("inv_q", 32'(q), 32'h0);
        repeat (4) cyc();

        do_reset();
        req = 4'b0001;
        req_idx = '0;
        cyc();
        chk("mid_t", 32'(t_out), 32'h01);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_q", 32'(q), 0);
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_t", 32'(t_out), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        mreset();
        req = '0;
        @(negedge clk);
        rst_n = 1;
        repeat (3) cyc();
        chk("mid_after_q", 32'(q), 0);

        do_reset();
        rnd = 1;
        repeat (3000) cyc();
        rnd = 0;
        repeat (40) cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
